nibble_sub_seq: RTL and testbench

- Multi-cycle controller that computes a W-bit difference A - B - bin by sequencing one 4-bit subtract slice over successive nibbles, LSB nibble first.
- Carries the borrow between cycles in a register.
- Sits between a requesting unit (start/done handshake) and the shared 4-bit subtractor datapath. Lets the lab design subtract 8/16/32-bit words without widening the slice.

---
 rtl/nibble_sub_seq_if.sv | 29 ++
 rtl/nibble_sub_seq.sv | 131 +++++++++++++
 tb/tb_nibble_sub_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_sub_seq_if.sv
// Request/result bundle between a requesting unit and the nibble-serial subtractor.
// Latency: none, wires only.
// Backpressure: none; the requester holds start and the slave answers with busy/done.
interface nibble_sub_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/nibble_sub_seq.sv
// Computes A - B - bin over W = 4*NIBBLES bits with one 4-bit slice, LSB nibble first.
// Latency: done pulses NIBBLES+1 cycles after the start edge (NIBBLES busy cycles, then one done cycle).
// Backpressure: start is only sampled in IDLE or DONE; a start during RUN is ignored, not queued.
module nibble_sub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  nibble_sub_seq_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [CW-1:0]  cnt;
  logic           brw;
  logic [W-1:0]   a_l;
  logic [W-1:0]   b_l;
  logic [W-1:0]   diff_q;
  logic           bout_q;
  logic           zero_q;
  logic           ovf_q;

  logic           load;
  logic           step;
  logic           last;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [4:0]     nib_sub;
  logic [W-1:0]   diff_nxt;

  assign last = (cnt == CW'(NIBBLES - 1));

  // State register; reset wins over everything, including a RUN in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus load/step strobes for the datapath.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Back-to-back start goes straight to RUN with the new operands.
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shared 4-bit slice: 5-bit subtract so bit 4 is the borrow out of this nibble.
  always_comb begin
    a_nib    = a_l[4*cnt +: 4];
    b_nib    = b_l[4*cnt +: 4];
    nib_sub  = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, brw};
    diff_nxt = diff_q;
    diff_nxt[4*cnt +: 4] = nib_sub[3:0];
  end

  // Operand latch, nibble sequencing and result flags; flags use the completed diff on the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_l    <= '0;
      b_l    <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      a_l    <= bus.a;
      b_l    <= bus.b;
      brw    <= bus.bin;
      cnt    <= '0;
      diff_q <= '0;
    end else if (step) begin
      diff_q <= diff_nxt;
      brw    <= nib_sub[4];
      if (last) begin
        cnt    <= '0;
        bout_q <= nib_sub[4];
        zero_q <= (diff_nxt == '0);
        ovf_q  <= (a_l[W-1] ^ b_l[W-1]) & (a_l[W-1] ^ diff_nxt[W-1]);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Directed bench for nibble_sub_seq at NIBBLES=4 with a result scoreboard.
// Latency: expects done one cycle after four busy cycles.
// Backpressure: exercises held start, start during RUN and reset mid-RUN.
module tb_nibble_sub_seq;
  localparam int NIB = 4;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;
  int   done_seen;
  exp_t exp_q[$];

  nibble_sub_seq_if #(.NIBBLES(NIB)) bus ();

  nibble_sub_seq #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done cycles so missing or extra pulses can be detected.
  always @(posedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    cmp_cnt++;
    assert (obs === want)
    else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] full;
    exp_t e;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    e.diff = full[15:0];
    e.bout = full[16];
    e.zero = (full[15:0] == 16'd0);
    e.ovf  = (a[15] ^ b[15]) & (a[15] ^ full[15]);
    exp_q.push_back(e);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input bit expect_result);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    bus.start = 1'b1;
    if (expect_result) push_exp(a, b, bi);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int nbusy);
    exp_t e;
    nbusy = 0;
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    if (bus.done === 1'b1) begin
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_diff"}, 32'(bus.diff), 32'(e.diff));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(e.bout));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(e.zero));
        chk({tag, "_ovf"},  32'(bus.ovf),  32'(e.ovf));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      end
    end
  endtask

  initial begin
    int nb;
    int d0;
    cmp_cnt   = 0;
    err_cnt   = 0;
    done_seen = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    // Reset for two cycles, then one idle cycle.
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'h0000);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);

    // Basic subtract with latency check.
    start_op(16'h1234, 16'h0111, 1'b0, 1'b1);
    wait_done("basic", nb);
    chk("basic_busy_cycles", 32'(nb), 32'd4);
    chk("basic_diff_lit", 32'(bus.diff), 32'h1123);
    tick();
    chk("basic_done_one_cycle", 32'(bus.done), 32'd0);
    chk("basic_idle_busy", 32'(bus.busy), 32'd0);

    // Unsigned wrap with borrow out.
    start_op(16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_done("wrap", nb);
    chk("wrap_diff_lit", 32'(bus.diff), 32'hFFFF);
    chk("wrap_busy_cycles", 32'(nb), 32'd4);
    tick();

    // Signed overflow.
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done("ovf", nb);
    chk("ovf_flag_lit", 32'(bus.ovf), 32'd1);
    tick();

    // Zero result with borrow-in; a changes mid-RUN and must not matter.
    start_op(16'h5A5A, 16'h5A59, 1'b1, 1'b1);
    tick();
    bus.a = 16'hFFFF;
    wait_done("zero", nb);
    chk("zero_busy_cycles", 32'(nb), 32'd3);
    chk("zero_flag_lit", 32'(bus.zero), 32'd1);
    tick();

    // Start held high: second op accepted straight out of DONE.
    d0        = done_seen;
    bus.a     = 16'h1234;
    bus.b     = 16'h0111;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    push_exp(16'h1234, 16'h0111, 1'b0);
    tick();
    wait_done("b2b_first", nb);
    chk("b2b_first_busy_cycles", 32'(nb), 32'd4);
    bus.a = 16'h0010;
    bus.b = 16'h0001;
    push_exp(16'h0010, 16'h0001, 1'b0);
    tick();
    chk("b2b_rerun_busy", 32'(bus.busy), 32'd1);
    chk("b2b_rerun_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    wait_done("b2b_second", nb);
    chk("b2b_second_busy_cycles", 32'(nb), 32'd4);
    chk("b2b_second_diff_lit", 32'(bus.diff), 32'h000F);
    tick();
    tick();
    tick();
    chk("b2b_done_count", 32'(done_seen - d0), 32'd2);
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);

    // Reset after two RUN edges discards the operation.
    d0 = done_seen;
    start_op(16'h1234, 16'h0111, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_diff", 32'(bus.diff), 32'h0000);
    tick();
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("midrst_no_done", 32'(done_seen - d0), 32'd0);
    start_op(16'h1234, 16'h0111, 1'b0, 1'b1);
    wait_done("after_rst", nb);
    chk("after_rst_diff_lit", 32'(bus.diff), 32'h1123);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
